inject_arbiter: RTL and testbench
=================================

INJECT_ARBITER -- requirements
Module: inject_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of requesting sources (2..16).
REQ-002 SHALL have parameter DW, default 32: flit width.
REQ-003 SHALL have parameter CREDIT_MAX, default 16: downstream buffer depth in flits.
REQ-004 SHALL have parameter CREDIT_W, default 5: credit counter width, with 2^CREDIT_W > CREDIT_MAX.
REQ-005 SHALL have port clk_i  in  1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst_i  in  1: reset, asynchronous, active-high.
REQ-007 SHALL have port src_valid_i  in  NUM_SRC: per-source flit valid.
REQ-008 SHALL have port src_last_i  in  NUM_SRC: per-source tail-flit marker.
REQ-009 SHALL have port src_data_i  in  NUM_SRC*DW: per-source flit, source k at bits [k*DW +: DW].
REQ-010 SHALL have port src_ready_o  out  NUM_SRC: per-source accept.
REQ-011 SHALL have port out_valid_o  out  1: flit to injection port.
REQ-012 SHALL have port out_data_o  out  DW: injected flit.
REQ-013 SHALL have port out_last_o  out  1: injected flit is tail.
REQ-014 SHALL have port credit_upd_i  in  1: one-cycle pulse, one downstream slot freed.
REQ-015 SHALL have port grant_o  out  NUM_SRC: one-hot current owner, all-zero when idle.
REQ-016 SHALL have port credits_o  out  CREDIT_W: current credit count.
REQ-017 SHALL have port credit_err_o  out  1: sticky credit-overflow flag.
REQ-018 SHALL have port flit_cnt_o  out  32: total flits injected, wraps at 2^32.

Function
REQ-019 SHALL implement two states, IDLE and LOCKED, in a registered FSM.
REQ-020 SHALL, in IDLE with any src_valid_i set, register a one-hot grant to the first valid source at or after rr_ptr (circular search) and enter LOCKED next cycle; arbitration latency is exactly 1 cycle.
REQ-021 SHALL, in IDLE with no valid source, remain IDLE and hold grant_o at zero.
REQ-022 SHALL hold the grant in LOCKED until the tail flit transfers; no re-arbitration mid-packet (wormhole).
REQ-023 SHALL drive out_valid_o = LOCKED & src_valid_i[g] & (credits_o != 0), combinationally from the owner g.
REQ-024 SHALL drive src_ready_o[g] = LOCKED & (credits_o != 0) for the owner only, and 0 for all others.
REQ-025 SHALL forward out_data_o and out_last_o combinationally from the owner, and drive them to 0 when not LOCKED.
REQ-026 SHALL define a transfer as out_valid_o high in a cycle; each transfer increments flit_cnt_o by 1.
REQ-027 SHALL, on a transfer with src_last_i[g]=1, return to IDLE, clear grant_o and set rr_ptr = (g+1) mod NUM_SRC, all on the next edge.
REQ-028 SHALL update credits as next = credits - transfer + credit_upd_i; a simultaneous transfer and credit_upd_i leaves credits unchanged.
REQ-029 SHALL keep credits at CREDIT_MAX when credit_upd_i arrives at CREDIT_MAX with no transfer, and set credit_err_o (sticky until reset).
REQ-030 SHALL keep credits_o nonnegative, because no transfer is possible at 0 credits (REQ-023).
REQ-031 SHALL allow a source dropping src_valid_i mid-packet; the lock is held and bubbles are permitted.
REQ-032 SHALL allow a single-flit packet (last on first flit), which returns to IDLE after one transfer.

Reset
REQ-033 SHALL, when rst_i is asserted, asynchronously force IDLE, rr_ptr=0, grant_o=0, credits_o=CREDIT_MAX, credit_err_o=0, flit_cnt_o=0, out_valid_o=0 and src_ready_o=0.
REQ-034 SHALL abandon any in-flight packet when reset asserts mid-packet, with no resumption; after release the first grant goes to the lowest valid index at or after source 0.

Verification
REQ-035 SHALL be verified by: all 4 sources valid, 3-flit packets, ample credits -> grants in order 0,1,2,3,0; one idle cycle between packets; flit_cnt_o=12 after 4 packets.
REQ-036 SHALL be verified by: CREDIT_MAX=16, no credit_upd_i, source 0 sends a 20-flit packet -> 16 flits pass, then out_valid_o=0 and credits_o=0; 4 credit_upd_i pulses -> remaining 4 flits pass, last flit returns to IDLE.
REQ-037 SHALL be verified by: transfer and credit_upd_i in the same cycle at credits_o=5 -> credits_o stays 5.
REQ-038 SHALL be verified by: credit_upd_i at credits_o=16 while idle -> credits_o=16 and credit_err_o=1, held until rst_i.
REQ-039 SHALL be verified by: source 2 locked, source 1 valid, source 2 deasserts valid for 3 cycles mid-packet -> grant_o stays 4'b0100 and source 1 is never ready.
REQ-040 SHALL be verified by: rst_i pulsed during the second flit of a packet -> outputs reach reset values in the same cycle; the packet is not resumed, and credits_o=16 after release.

Source files
------------

// File: rtl/inject_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : inject_arbiter
//  Purpose  : Wormhole round-robin arbiter feeding one network injection port.
//             Several sources compete for the port. A winner is picked from a
//             rotating start pointer and keeps the port until its tail flit
//             has been sent. Injection is throttled by a downstream credit
//             counter, which is replenished by credit_upd_i pulses.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i         in   1              rising-edge clock
//    rst_i         in   1              asynchronous active-high reset
//    src_valid_i   in   NUM_SRC        per-source flit valid
//    src_last_i    in   NUM_SRC        per-source tail-flit marker
//    src_data_i    in   NUM_SRC*DW     source k flit at [k*DW +: DW]
//    src_ready_o   out  NUM_SRC        accept, asserted only for the owner
//    out_valid_o   out  1              flit presented to the injection port
//    out_data_o    out  DW             injected flit
//    out_last_o    out  1              injected flit is a tail
//    credit_upd_i  in   1              one downstream slot freed
//    grant_o       out  NUM_SRC        one-hot owner, zero when idle
//    credits_o     out  CREDIT_W       current credit count
//    credit_err_o  out  1              sticky credit-overflow flag
//    flit_cnt_o    out  32             total injected flits (wrapping)
// ============================================================================
module inject_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DW         = 32,
    parameter int CREDIT_MAX = 16,
    parameter int CREDIT_W   = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_SRC-1:0]    src_valid_i,
    input  logic [NUM_SRC-1:0]    src_last_i,
    input  logic [NUM_SRC*DW-1:0] src_data_i,
    output logic [NUM_SRC-1:0]    src_ready_o,
    output logic                  out_valid_o,
    output logic [DW-1:0]         out_data_o,
    output logic                  out_last_o,
    input  logic                  credit_upd_i,
    output logic [NUM_SRC-1:0]    grant_o,
    output logic [CREDIT_W-1:0]   credits_o,
    output logic                  credit_err_o,
    output logic [31:0]           flit_cnt_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    // One extra bit so the circular search sum can exceed NUM_SRC-1 before
    // it is folded back into range.
    localparam logic [IDX_W:0]    c_NUM_SRC    = (IDX_W+1)'(NUM_SRC);
    localparam logic [IDX_W-1:0]  c_LAST_IDX   = IDX_W'(NUM_SRC - 1);
    localparam logic [CREDIT_W-1:0] c_CREDIT_MAX = CREDIT_W'(CREDIT_MAX);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]          r_state;
    logic [NUM_SRC-1:0]  r_grant;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [CREDIT_W-1:0] r_credits;
    logic                r_credit_err;
    logic [31:0]         r_flit_cnt;

    logic [0:0]          w_state_nxt;
    logic [NUM_SRC-1:0]  w_grant_nxt;
    logic [IDX_W-1:0]    w_owner_nxt;
    logic [IDX_W-1:0]    w_rr_nxt;
    logic [CREDIT_W-1:0] w_credits_nxt;
    logic                w_credit_err_nxt;

    // ------------------------------------------------------------------------
    // Circular search: first valid source at or after r_rr_ptr
    // ------------------------------------------------------------------------
    logic [IDX_W:0]      w_sum;
    logic                w_found;
    logic [IDX_W-1:0]    w_pick;
    logic [NUM_SRC-1:0]  w_pick_oh;

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
            if (w_sum >= c_NUM_SRC) begin
                w_sum = w_sum - c_NUM_SRC;
            end
            if (!w_found && src_valid_i[w_sum[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IDX_W-1:0];
            end
        end
    end

    assign w_pick_oh = NUM_SRC'(1) << w_pick;

    // ------------------------------------------------------------------------
    // Owner multiplexer. The registered grant is one-hot (or zero when idle),
    // so an AND-OR mux yields zero for every field whenever nobody owns the
    // port; that covers the "outputs low when not locked" behaviour for free.
    // ------------------------------------------------------------------------
    logic                w_own_valid;
    logic                w_own_last;
    logic [DW-1:0]       w_own_data;

    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_own_valid = w_own_valid | (r_grant[k] & src_valid_i[k]);
            w_own_last  = w_own_last  | (r_grant[k] & src_last_i[k]);
            w_own_data  = w_own_data  | ({DW{r_grant[k]}} & src_data_i[k*DW +: DW]);
        end
    end

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic w_locked;
    logic w_credit_ok;
    logic w_xfer;

    assign w_locked    = (r_state == c_ST_LOCKED);
    assign w_credit_ok = (r_credits != '0);
    // A flit moves whenever it is presented: the downstream side has no
    // back-pressure other than credits, which are already folded in here.
    assign w_xfer      = w_locked & w_own_valid & w_credit_ok;

    assign out_valid_o = w_xfer;
    assign out_data_o  = w_locked ? w_own_data : '0;
    assign out_last_o  = w_locked & w_own_last;
    assign src_ready_o = r_grant & {NUM_SRC{w_locked & w_credit_ok}};

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = c_ST_LOCKED;
                    w_grant_nxt = w_pick_oh;
                    w_owner_nxt = w_pick;
                end else begin
                    w_grant_nxt = '0;
                end
            end
            c_ST_LOCKED: begin
                // Only the tail releases the port; bubbles from the owner
                // simply stall here without re-arbitrating.
                if (w_xfer && w_own_last) begin
                    w_state_nxt = c_ST_IDLE;
                    w_grant_nxt = '0;
                    w_rr_nxt    = (r_owner == c_LAST_IDX) ? '0 : r_owner + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Credit bookkeeping. A return while already full would overflow the
    // downstream buffer model, so the count saturates and the error latches.
    // ------------------------------------------------------------------------
    always_comb begin
        w_credits_nxt    = r_credits;
        w_credit_err_nxt = r_credit_err;
        if (w_xfer && !credit_upd_i) begin
            w_credits_nxt = r_credits - CREDIT_W'(1);
        end else if (!w_xfer && credit_upd_i) begin
            if (r_credits >= c_CREDIT_MAX) begin
                w_credits_nxt    = c_CREDIT_MAX;
                w_credit_err_nxt = 1'b1;
            end else begin
                w_credits_nxt = r_credits + CREDIT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= c_ST_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_credits    <= c_CREDIT_MAX;
            r_credit_err <= 1'b0;
            r_flit_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_owner      <= w_owner_nxt;
            r_rr_ptr     <= w_rr_nxt;
            r_credits    <= w_credits_nxt;
            r_credit_err <= w_credit_err_nxt;
            if (w_xfer) begin
                r_flit_cnt <= r_flit_cnt + 32'd1;
            end
        end
    end

    assign grant_o      = r_grant;
    assign credits_o    = r_credits;
    assign credit_err_o = r_credit_err;
    assign flit_cnt_o   = r_flit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_inject_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inject_arbiter
//  Purpose  : Self-checking bench for inject_arbiter. Sources are modelled as
//             packet generators; every flit they will emit is queued in a
//             scoreboard in the order the arbiter must inject it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inject_arbiter;

    localparam int NS   = 4;
    localparam int DW   = 32;
    localparam int CMAX = 16;
    localparam int CW   = 5;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NS-1:0]     src_valid_i;
    logic [NS-1:0]     src_last_i;
    logic [NS*DW-1:0]  src_data_i;
    logic [NS-1:0]     src_ready_o;
    logic              out_valid_o;
    logic [DW-1:0]     out_data_o;
    logic              out_last_o;
    logic              credit_upd_i;
    logic [NS-1:0]     grant_o;
    logic [CW-1:0]     credits_o;
    logic              credit_err_o;
    logic [31:0]       flit_cnt_o;

    inject_arbiter #(
        .NUM_SRC    (NS),
        .DW         (DW),
        .CREDIT_MAX (CMAX),
        .CREDIT_W   (CW)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .src_valid_i  (src_valid_i),
        .src_last_i   (src_last_i),
        .src_data_i   (src_data_i),
        .src_ready_o  (src_ready_o),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .credit_upd_i (credit_upd_i),
        .grant_o      (grant_o),
        .credits_o    (credits_o),
        .credit_err_o (credit_err_o),
        .flit_cnt_o   (flit_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } flit_t;

    flit_t         sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            pkts[NS];
    int            plen[NS];
    int            idx[NS];
    int            sent[NS];
    logic [NS-1:0] hold;
    int            n_xfer;
    int            n_tail;

    function automatic logic [DW-1:0] flit_data(int s, int p, int i);
        return (32'(s) << 28) | (32'(p) << 16) | 32'(i) | 32'h0A00_0000;
    endfunction

    task automatic push_pkt(int s, int p, int len);
        for (int i = 0; i < len; i++) begin
            flit_t f;
            f.data = flit_data(s, p, i);
            f.last = (i == len - 1);
            sb.push_back(f);
        end
    endtask

    task automatic drive_srcs();
        for (int s = 0; s < NS; s++) begin
            src_valid_i[s]          = (pkts[s] > 0) && !hold[s];
            src_last_i[s]           = (pkts[s] > 0) && (idx[s] == plen[s] - 1);
            src_data_i[s*DW +: DW]  = (pkts[s] > 0) ? flit_data(s, sent[s], idx[s]) : '0;
        end
    endtask

    task automatic bench_clear();
        for (int s = 0; s < NS; s++) begin
            pkts[s] = 0; plen[s] = 1; idx[s] = 0; sent[s] = 0;
        end
        hold         = '0;
        n_xfer       = 0;
        n_tail       = 0;
        credit_upd_i = 1'b0;
        sb.delete();
    endtask

    // One clock: observe at the falling edge (scoreboard pop on every
    // injected flit, source bookkeeping on handshakes), then drive new
    // source values just after the rising edge.
    task automatic cycle();
        flit_t e;
        @(negedge clk_i);
        if (out_valid_o) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got last=%0b data=%h, required no flit", out_last_o, out_data_o);
            end else begin
                e = sb.pop_front();
                if ({out_last_o, out_data_o} !== {e.last, e.data}) begin
                    n_err++;
                    $display("FAIL sb_flit: got last=%0b data=%h, required last=%0b data=%h",
                             out_last_o, out_data_o, e.last, e.data);
                end
            end
            n_xfer++;
            if (out_last_o) n_tail++;
        end
        for (int s = 0; s < NS; s++) begin
            if (src_valid_i[s] && src_ready_o[s]) begin
                if (idx[s] == plen[s] - 1) begin
                    idx[s] = 0; pkts[s]--; sent[s]++;
                end else begin
                    idx[s]++;
                end
            end
        end
        @(posedge clk_i);
        #1;
        drive_srcs();
    endtask

    task automatic drain(string name);
        for (int c = 0; c < 100 && !(sb.size() == 0 && grant_o == '0); c++) cycle();
        n_cmp++;
        if (sb.size() != 0 || grant_o !== '0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d flits pending grant=%b, required 0 pending grant=0000",
                     name, sb.size(), grant_o);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        bench_clear();
        drive_srcs();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        drive_srcs();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_i = 1'b1;
        bench_clear();
        drive_srcs();
        #1;
        n_cmp++;
        if ({grant_o, credits_o, credit_err_o, flit_cnt_o} !== {4'b0000, 5'd16, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_regs: got grant=%b credits=%0d err=%0b cnt=%0d, required 0000/16/0/0",
                     grant_o, credits_o, credit_err_o, flit_cnt_o);
        end
        n_cmp++;
        if ({out_valid_o, src_ready_o, out_last_o, out_data_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outs: got valid=%0b ready=%b last=%0b data=%h, required all zero",
                     out_valid_o, src_ready_o, out_last_o, out_data_o);
        end
        do_reset();
        cycle();
        n_cmp++;
        if (grant_o !== '0 || out_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_req: got grant=%b valid=%0b, required 0000/0", grant_o, out_valid_o);
        end
    endtask

    task automatic test_round_robin();
        logic [NS-1:0] exp_order[5];
        logic [NS-1:0] prev;
        int            k;
        int            tails_prev;
        bit            done12;
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        do_reset();
        for (int s = 0; s < NS; s++) begin plen[s] = 3; pkts[s] = 1; end
        pkts[0] = 2;
        push_pkt(0, 0, 3); push_pkt(1, 0, 3); push_pkt(2, 0, 3); push_pkt(3, 0, 3); push_pkt(0, 1, 3);
        drive_srcs();
        prev = '0; k = 0; tails_prev = 0; done12 = 0;
        for (int c = 0; c < 200 && !(sb.size() == 0 && grant_o == '0); c++) begin
            cycle();
            if (n_tail != tails_prev) begin
                tails_prev = n_tail;
                n_cmp++;
                if (grant_o !== '0) begin
                    n_err++;
                    $display("FAIL rr_idle_gap: got grant=%b after tail, required 0000", grant_o);
                end
            end
            if (grant_o != '0 && grant_o != prev) begin
                n_cmp++;
                if (k >= 5) begin
                    n_err++;
                    $display("FAIL rr_order: got extra grant=%b, required none", grant_o);
                end else if (grant_o !== exp_order[k]) begin
                    n_err++;
                    $display("FAIL rr_order: got grant=%b at #%0d, required %b", grant_o, k, exp_order[k]);
                end
                k++;
            end
            prev = grant_o;
            if (n_tail == 4 && !done12) begin
                done12 = 1;
                n_cmp++;
                if (flit_cnt_o !== 32'd12) begin
                    n_err++;
                    $display("FAIL rr_cnt12: got %0d, required 12", flit_cnt_o);
                end
            end
        end
        n_cmp++;
        if (k != 5 || flit_cnt_o !== 32'd15 || credits_o !== 5'd1 || sb.size() != 0) begin
            n_err++;
            $display("FAIL rr_end: got grants=%0d cnt=%0d credits=%0d pending=%0d, required 5/15/1/0",
                     k, flit_cnt_o, credits_o, sb.size());
        end
    endtask

    task automatic test_credit_stall();
        do_reset();
        plen[0] = 20; pkts[0] = 1;
        push_pkt(0, 0, 20);
        drive_srcs();
        for (int c = 0; c < 100 && n_xfer < 16; c++) cycle();
        repeat (3) begin
            cycle();
            n_cmp++;
            if (out_valid_o !== 1'b0 || credits_o !== '0 || grant_o !== 4'b0001 || n_xfer != 16) begin
                n_err++;
                $display("FAIL stall: got valid=%0b credits=%0d grant=%b xfers=%0d, required 0/0/0001/16",
                         out_valid_o, credits_o, grant_o, n_xfer);
            end
        end
        repeat (4) begin
            credit_upd_i = 1'b1;
            cycle();
        end
        credit_upd_i = 1'b0;
        drain("stall");
        n_cmp++;
        if (n_xfer != 20 || flit_cnt_o !== 32'd20 || credits_o !== '0) begin
            n_err++;
            $display("FAIL stall_end: got xfers=%0d cnt=%0d credits=%0d, required 20/20/0",
                     n_xfer, flit_cnt_o, credits_o);
        end
    endtask

    task automatic test_credit_simul();
        do_reset();
        plen[0] = 13; pkts[0] = 1;
        push_pkt(0, 0, 13);
        drive_srcs();
        for (int c = 0; c < 50 && credits_o != 5'd5; c++) cycle();
        n_cmp++;
        if (credits_o !== 5'd5 || out_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL simul_pre: got credits=%0d valid=%0b, required 5/1", credits_o, out_valid_o);
        end
        credit_upd_i = 1'b1;
        cycle();
        credit_upd_i = 1'b0;
        n_cmp++;
        if (credits_o !== 5'd5 || n_xfer != 12) begin
            n_err++;
            $display("FAIL simul_hold: got credits=%0d xfers=%0d, required 5/12", credits_o, n_xfer);
        end
        drain("simul");
        n_cmp++;
        if (credits_o !== 5'd4) begin
            n_err++;
            $display("FAIL simul_end: got credits=%0d, required 4", credits_o);
        end
    endtask

    task automatic test_credit_overflow();
        do_reset();
        credit_upd_i = 1'b1;
        cycle();
        credit_upd_i = 1'b0;
        n_cmp++;
        if (credits_o !== 5'd16 || credit_err_o !== 1'b1) begin
            n_err++;
            $display("FAIL ovf: got credits=%0d err=%0b, required 16/1", credits_o, credit_err_o);
        end
        // single-flit packet; search from 0 must still find source 3
        plen[3] = 1; pkts[3] = 1;
        push_pkt(3, 0, 1);
        drive_srcs();
        cycle();
        n_cmp++;
        if (grant_o !== 4'b1000 || out_valid_o !== 1'b1 || out_last_o !== 1'b1) begin
            n_err++;
            $display("FAIL single_flit: got grant=%b valid=%0b last=%0b, required 1000/1/1",
                     grant_o, out_valid_o, out_last_o);
        end
        cycle();
        n_cmp++;
        if (grant_o !== '0 || credit_err_o !== 1'b1 || credits_o !== 5'd15 || sb.size() != 0) begin
            n_err++;
            $display("FAIL ovf_sticky: got grant=%b err=%0b credits=%0d pending=%0d, required 0000/1/15/0",
                     grant_o, credit_err_o, credits_o, sb.size());
        end
        do_reset();
        n_cmp++;
        if (credit_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got err=%0b, required 0", credit_err_o);
        end
    endtask

    task automatic test_bubble();
        do_reset();
        plen[2] = 6; pkts[2] = 1;
        plen[1] = 2; pkts[1] = 1;
        hold[1] = 1'b1;
        push_pkt(2, 0, 6); push_pkt(1, 0, 2);
        drive_srcs();
        cycle();
        n_cmp++;
        if (grant_o !== 4'b0100) begin
            n_err++;
            $display("FAIL bubble_grant: got %b, required 0100", grant_o);
        end
        hold[1] = 1'b0;
        drive_srcs();
        cycle(); cycle();
        hold[2] = 1'b1;
        drive_srcs();
        repeat (3) begin
            cycle();
            n_cmp++;
            if (grant_o !== 4'b0100 || src_ready_o[1] !== 1'b0 || out_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL bubble_hold: got grant=%b ready1=%0b valid=%0b, required 0100/0/0",
                         grant_o, src_ready_o[1], out_valid_o);
            end
        end
        hold[2] = 1'b0;
        drive_srcs();
        for (int c = 0; c < 40 && !(sb.size() == 0 && grant_o == '0); c++) begin
            cycle();
            if (grant_o == 4'b0100) begin
                n_cmp++;
                if (src_ready_o[1] !== 1'b0) begin
                    n_err++;
                    $display("FAIL bubble_ready1: got 1, required 0");
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0 || n_tail != 2) begin
            n_err++;
            $display("FAIL bubble_end: got pending=%0d tails=%0d, required 0/2", sb.size(), n_tail);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        plen[0] = 4; pkts[0] = 1;
        push_pkt(0, 0, 4);
        drive_srcs();
        cycle(); cycle();
        n_cmp++;
        if (out_valid_o !== 1'b1 || flit_cnt_o !== 32'd1) begin
            n_err++;
            $display("FAIL mid_pre: got valid=%0b cnt=%0d, required 1/1", out_valid_o, flit_cnt_o);
        end
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid_o, src_ready_o, grant_o, credits_o, flit_cnt_o} !== {1'b0, 4'b0, 4'b0, 5'd16, 32'd0}) begin
            n_err++;
            $display("FAIL mid_async: got valid=%0b ready=%b grant=%b credits=%0d cnt=%0d, required 0/0000/0000/16/0",
                     out_valid_o, src_ready_o, grant_o, credits_o, flit_cnt_o);
        end
        bench_clear();
        drive_srcs();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (3) cycle();
        n_cmp++;
        if (grant_o !== '0 || credits_o !== 5'd16 || n_xfer != 0) begin
            n_err++;
            $display("FAIL mid_noresume: got grant=%b credits=%0d xfers=%0d, required 0000/16/0",
                     grant_o, credits_o, n_xfer);
        end
        plen[1] = 1; pkts[1] = 1;
        plen[3] = 1; pkts[3] = 1;
        push_pkt(1, 0, 1); push_pkt(3, 0, 1);
        drive_srcs();
        cycle();
        n_cmp++;
        if (grant_o !== 4'b0010) begin
            n_err++;
            $display("FAIL mid_first_grant: got %b, required 0010", grant_o);
        end
        drain("mid");
    endtask

    initial begin
        bench_clear();
        rst_i = 1'b1;
        drive_srcs();
        test_reset();
        test_round_robin();
        test_credit_stall();
        test_credit_simul();
        test_credit_overflow();
        test_bubble();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
